// File: rtl/mfp_ahb_lite_master_pkg.sv
// mfp_ahb_lite_master_pkg: AHB-Lite encodings, slot record and command legality check.
package mfp_ahb_lite_master_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE    = 3'd0;
  localparam logic [2:0] HSIZE_HALF    = 3'd1;
  localparam logic [2:0] HSIZE_WORD    = 3'd2;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bad;
  } slot_t;
  function automatic logic is_bad(input logic [2:0] size, input logic [1:0] addr);
    return size > HSIZE_WORD || (size == HSIZE_HALF && addr[0]) || (size == HSIZE_WORD && addr != 2'b00);
  endfunction
endpackage

// File: rtl/mfp_ahb_lite_lane_steer.sv
// mfp_ahb_lite_lane_steer: combinational byte-lane steering.
//   size/addr/big_endian select the lanes; wdata -> hwdata replicates narrow
//   writes across all lanes; hrdata -> rdata extracts and zero-extends reads.
module mfp_ahb_lite_lane_steer
  import mfp_ahb_lite_master_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr,
  input  logic        big_endian,
  input  logic [31:0] wdata,
  input  logic [31:0] hrdata,
  output logic [31:0] hwdata,
  output logic [31:0] rdata
);
  logic [1:0] byte_lane;
  logic       half_lane;
  // big-endian lane index is the mirror: 3-addr for bytes, ~addr[1] for halves
  assign byte_lane = big_endian ? ~addr : addr;
  assign half_lane = big_endian ? ~addr[1] : addr[1];
  assign hwdata = size == HSIZE_BYTE ? {4{wdata[7:0]}} :
                  size == HSIZE_HALF ? {2{wdata[15:0]}} : wdata;
  assign rdata  = size == HSIZE_BYTE ? {24'd0, hrdata[{byte_lane, 3'b000} +: 8]} :
                  size == HSIZE_HALF ? {16'd0, hrdata[{half_lane, 4'b0000} +: 16]} : hrdata;
endmodule

// File: rtl/mfp_ahb_lite_master_port.sv
// mfp_ahb_lite_master_port: valid/ready command stream to pipelined AHB-Lite single transfers.
//   cmd_*  : command in (valid/ready), one in-order response per command on rsp_*
//   H*     : AHB-Lite initiator bus toward the matrix; SI_Endian selects lane mapping
//   A-slot drives the address phase, D-slot the data phase; both advance on HREADY.
module mfp_ahb_lite_master_port
  import mfp_ahb_lite_master_pkg::*;
#(
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic        SI_Endian
);
  slot_t       a, d, cmd_slot;
  logic        accept;
  logic [31:0] rdata_x;
  logic        unused_addr;
  assign cmd_ready = ~a.valid | HREADY;
  assign accept    = cmd_valid & cmd_ready;
  assign cmd_slot  = '{valid: 1'b1, write: cmd_write, size: cmd_size, addr: cmd_addr,
                       wdata: cmd_wdata, bad: is_bad(cmd_size, cmd_addr[1:0])};
  // an empty A-slot may be filled during a wait state; it then simply waits its turn
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a <= '0;
      d <= '0;
    end else if (HREADY) begin
      d <= a;
      a <= accept ? cmd_slot : '0;
    end else if (accept) begin
      a <= cmd_slot;
    end
  end
  // bad commands ride the pipeline as IDLE so their error response stays in order
  assign HTRANS    = a.valid & ~a.bad ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = a.addr;
  assign HSIZE     = a.size;
  assign HWRITE    = a.write;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VALUE;
  mfp_ahb_lite_lane_steer u_steer (
    .size       (d.size),
    .addr       (d.addr[1:0]),
    .big_endian (SI_Endian),
    .wdata      (d.wdata),
    .hrdata     (HRDATA),
    .hwdata     (HWDATA),
    .rdata      (rdata_x)
  );
  assign rsp_valid   = d.valid & HREADY;
  assign rsp_error   = d.valid & (d.bad | HRESP);
  assign rsp_rdata   = rsp_valid & ~d.write & ~rsp_error ? rdata_x : 32'd0;
  assign unused_addr = ^d.addr[31:2];
endmodule

// File: tb/tb_mfp_ahb_lite_master_port.sv
// tb_mfp_ahb_lite_master_port: directed and randomized checks against a transaction-level model.
module tb_mfp_ahb_lite_master_port;
  logic        HCLK = 0;
  logic        HRESET, cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP, SI_Endian;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  always #5 HCLK = ~HCLK;

  mfp_ahb_lite_master_port dut (
    .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .SI_Endian(SI_Endian)
  );

  typedef struct {
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        bad;
  } cmd_t;

  int          checks = 0, failures = 0;
  cmd_t        rq[$], iq[$], dq[$];
  logic        hold_valid = 0;
  logic [31:0] hold_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_bad(input logic [2:0] size, input logic [31:0] addr);
    return size > 2 || (size == 1 && addr % 2 != 0) || (size == 2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] lanes(input cmd_t c);
    if (c.size == 0) return (c.wdata & 32'hFF) * 32'h01010101;
    if (c.size == 1) return (c.wdata & 32'hFFFF) * 32'h00010001;
    return c.wdata;
  endfunction

  function automatic logic [31:0] extract(input cmd_t c, input logic [31:0] hr, input logic be);
    int lane;
    if (c.size == 0) begin
      lane = int'(c.addr % 4);
      if (be) lane = 3 - lane;
      return (hr >> (8 * lane)) & 32'hFF;
    end
    if (c.size == 1) begin
      lane = int'((c.addr / 2) % 2);
      if (be) lane = 1 - lane;
      return (hr >> (16 * lane)) & 32'hFFFF;
    end
    return hr;
  endfunction

  task automatic model_check();
    cmd_t c;
    logic err;
    if (rsp_valid === 1'b1) begin
      chk("rsp_pending", 32'(rq.size() > 0), 1);
      if (rq.size() > 0) begin
        c = rq.pop_front();
        err = c.bad | HRESP;
        chk("rsp_error", 32'(rsp_error), 32'(err));
        chk("rsp_rdata", rsp_rdata, (c.write || err) ? 32'd0 : extract(c, HRDATA, SI_Endian));
      end
    end
    if (hold_valid) begin
      chk("hold_htrans", 32'(HTRANS), 2);
      chk("hold_haddr", HADDR, hold_addr);
    end
    if (dq.size() > 0) begin
      if (dq[0].write) chk("hwdata", HWDATA, lanes(dq[0]));
      if (HREADY) void'(dq.pop_front());
    end
    if (HTRANS === 2'b10) begin
      chk("nonseq_pending", 32'(iq.size() > 0), 1);
      if (iq.size() > 0) begin
        chk("haddr", HADDR, iq[0].addr);
        chk("hsize", 32'(HSIZE), 32'(iq[0].size));
        chk("hwrite", 32'(HWRITE), 32'(iq[0].write));
        if (HREADY) dq.push_back(iq.pop_front());
      end
    end
    hold_valid = (HTRANS === 2'b10) && !HREADY;
    hold_addr  = HADDR;
    if (HRESET) begin
      rq.delete();
      iq.delete();
      dq.delete();
      hold_valid = 0;
    end else if (cmd_valid && cmd_ready === 1'b1) begin
      c = '{cmd_write, cmd_size, cmd_addr, cmd_wdata, is_bad(cmd_size, cmd_addr)};
      rq.push_back(c);
      if (!c.bad) iq.push_back(c);
    end
  endtask

  task automatic cyc(input logic cv, input logic w, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic rdy, input logic resp, input logic [31:0] rd);
    @(negedge HCLK);
    cmd_valid = cv; cmd_write = w; cmd_size = sz; cmd_addr = a; cmd_wdata = wd;
    HREADY = rdy; HRESP = resp; HRDATA = rd;
    #1;
    model_check();
  endtask

  task automatic idle(input logic rdy);
    cyc(0, 0, 0, 0, 0, rdy, 0, 32'h5A5A5A5A);
  endtask

  initial begin
    logic err2;
    logic cv, w, rdy, resp;
    logic [2:0] sz;
    logic [31:0] a;
    HRESET = 1; SI_Endian = 0; err2 = 0;
    idle(1); idle(1);
    HRESET = 0;
    idle(1);
    chk("rst_htrans", 32'(HTRANS), 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hsize", 32'(HSIZE), 0);
    chk("rst_hwrite", 32'(HWRITE), 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_error", 32'(rsp_error), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("hburst", 32'(HBURST), 0);
    chk("hprot", 32'(HPROT), 32'h3);
    chk("hmastlock", 32'(HMASTLOCK), 0);

    cyc(1, 1, 2, 32'h80000010, 32'hDEADBEEF, 1, 0, 0);
    chk("t1_ready", 32'(cmd_ready), 1);
    idle(1);
    chk("t1_htrans", 32'(HTRANS), 2);
    chk("t1_haddr", HADDR, 32'h80000010);
    chk("t1_no_rsp", 32'(rsp_valid), 0);
    idle(1);
    chk("t1_hwdata", HWDATA, 32'hDEADBEEF);
    chk("t1_rsp_valid", 32'(rsp_valid), 1);
    chk("t1_rsp_error", 32'(rsp_error), 0);

    SI_Endian = 1;
    cyc(1, 0, 0, 32'h80000013, 0, 1, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'hAABBCCDD);
    chk("t2_be_valid", 32'(rsp_valid), 1);
    chk("t2_be_rdata", rsp_rdata, 32'h000000DD);
    SI_Endian = 0;
    cyc(1, 0, 0, 32'h80000013, 0, 1, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'hAABBCCDD);
    chk("t2_le_rdata", rsp_rdata, 32'h000000AA);

    cyc(1, 1, 2, 32'h100, 32'h1, 1, 0, 0);
    cyc(1, 1, 2, 32'h104, 32'h2, 1, 0, 0);
    chk("t3_nonseq1", 32'(HTRANS), 2);
    chk("t3_addr1", HADDR, 32'h100);
    cyc(1, 1, 2, 32'h108, 32'h3, 1, 0, 0);
    chk("t3_nonseq2", 32'(HTRANS), 2);
    chk("t3_rsp1", 32'(rsp_valid), 1);
    idle(1);
    chk("t3_nonseq3", 32'(HTRANS), 2);
    chk("t3_addr3", HADDR, 32'h108);
    chk("t3_rsp2", 32'(rsp_valid), 1);
    idle(1);
    chk("t3_rsp3", 32'(rsp_valid), 1);
    chk("t3_idle", 32'(HTRANS), 0);
    idle(1);
    chk("t3_no_rsp", 32'(rsp_valid), 0);

    cyc(1, 1, 2, 32'h200, 32'h11111111, 1, 0, 0);
    cyc(1, 1, 2, 32'h204, 32'h22222222, 1, 0, 0);
    cyc(1, 1, 2, 32'h208, 32'h33333333, 1, 0, 0);
    chk("t4_rsp1", 32'(rsp_valid), 1);
    for (int i = 0; i < 2; i++) begin
      idle(0);
      chk("t4_ready_low", 32'(cmd_ready), 0);
      chk("t4_htrans", 32'(HTRANS), 2);
      chk("t4_haddr", HADDR, 32'h208);
      chk("t4_hwdata", HWDATA, 32'h22222222);
      chk("t4_no_rsp", 32'(rsp_valid), 0);
    end
    idle(1);
    chk("t4_rsp2", 32'(rsp_valid), 1);
    chk("t4_ready", 32'(cmd_ready), 1);
    idle(1);
    chk("t4_rsp3", 32'(rsp_valid), 1);
    idle(1);
    chk("t4_done", 32'(rsp_valid), 0);

    cyc(1, 0, 2, 32'h300, 0, 1, 0, 0);
    cyc(1, 1, 2, 32'h304, 32'hCAFEF00D, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
    chk("t5_no_rsp", 32'(rsp_valid), 0);
    chk("t5_a_kept", 32'(HTRANS), 2);
    cyc(0, 0, 0, 0, 0, 1, 1, 32'hFFFFFFFF);
    chk("t5_rsp", 32'(rsp_valid), 1);
    chk("t5_err", 32'(rsp_error), 1);
    chk("t5_rdata", rsp_rdata, 0);
    idle(1);
    chk("t5_w_rsp", 32'(rsp_valid), 1);
    chk("t5_w_err", 32'(rsp_error), 0);
    chk("t5_w_hwdata", HWDATA, 32'hCAFEF00D);

    cyc(1, 1, 1, 32'h80000001, 32'h1234, 1, 0, 0);
    idle(1);
    chk("t6_idle", 32'(HTRANS), 0);
    idle(1);
    chk("t6_rsp", 32'(rsp_valid), 1);
    chk("t6_err", 32'(rsp_error), 1);

    cyc(1, 0, 2, 32'h400, 0, 1, 0, 0);
    idle(1);
    chk("t7_nonseq", 32'(HTRANS), 2);
    HRESET = 1;
    idle(0);
    HRESET = 0;
    idle(1);
    chk("t7_idle", 32'(HTRANS), 0);
    chk("t7_no_rsp", 32'(rsp_valid), 0);
    idle(1);
    chk("t7_no_rsp2", 32'(rsp_valid), 0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) SI_Endian = 1'($urandom);
      cv = ($urandom % 3) != 0;
      w  = 1'($urandom);
      sz = ($urandom % 8 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom % 4 != 0 && sz <= 2) a = a & ~((32'd1 << sz) - 1);
      if (err2) begin
        rdy = 1; resp = 1; err2 = 0;
      end else if (dq.size() > 0 && $urandom % 10 == 0) begin
        rdy = 0; resp = 1; err2 = 1;
      end else begin
        rdy = ($urandom % 4) != 0; resp = 0;
      end
      cyc(cv, w, sz, a, $urandom, rdy, resp, $urandom);
    end
    for (int i = 0; i < 10; i++) idle(1);
    chk("drain_rsp", 32'(rq.size()), 0);
    chk("drain_addr", 32'(iq.size()), 0);
    chk("drain_data", 32'(dq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
